// File: rtl/eth_rx_hdr_parse_pkg.sv
// rtl/eth_rx_hdr_parse_pkg.sv - shared constants for the Ethernet RX header parser
package eth_rx_hdr_parse_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_DROP    = 2'd3;

  localparam int ETH_HDR_LEN = 14;
  localparam int MAC_W       = 48;
  localparam int TYPE_W      = 16;
  localparam int HDR_W       = 2 * MAC_W + TYPE_W;

  // Counter value of the final header byte (dest + src + type).
  function automatic logic is_last_hdr_byte(input logic [3:0] cnt);
    return cnt == 4'(ETH_HDR_LEN - 1);
  endfunction

endpackage

// File: rtl/eth_rx_hdr_parse_axis_reg_1.sv
// rtl/eth_rx_hdr_parse_axis_reg_1.sv - single-stage stream register slice
module eth_rx_hdr_parse_axis_reg_1 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic                  in_tlast,
  input  logic                  in_tuser,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast,
  output logic                  out_tuser
);

  assign in_tready = out_tready | ~out_tvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tuser  <= 1'b0;
    end else if (in_tready) begin
      out_tvalid <= in_tvalid;
      if (in_tvalid) begin
        out_tdata <= in_tdata;
        out_tlast <= in_tlast;
        out_tuser <= in_tuser;
      end
    end
  end

endmodule

// File: rtl/eth_rx_hdr_parse.sv
// rtl/eth_rx_hdr_parse.sv - splits an Ethernet frame stream into header fields and payload stream
module eth_rx_hdr_parse
  import eth_rx_hdr_parse_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_hdr_valid,
  input  logic                  m_hdr_ready,
  output logic [MAC_W-1:0]      m_dest_mac,
  output logic [MAC_W-1:0]      m_src_mac,
  output logic [TYPE_W-1:0]     m_eth_type,
  output logic [DATA_WIDTH-1:0] m_payload_tdata,
  output logic                  m_payload_tvalid,
  input  logic                  m_payload_tready,
  output logic                  m_payload_tlast,
  output logic                  m_payload_tuser,
  output logic                  busy,
  output logic                  error_hdr_early_term
);

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("eth_rx_hdr_parse: DATA_WIDTH must be 8");
  end

  logic [1:0]       state;
  logic [3:0]       hdr_cnt;
  logic [HDR_W-1:0] hdr_sr;
  logic             hdr_valid_q;
  logic             err_q;
  logic             s_acc;
  logic             pay_in_valid;
  logic             pay_in_ready;

  assign s_acc        = s_axis_tvalid & s_axis_tready;
  assign pay_in_valid = (state == ST_PAYLOAD) & s_axis_tvalid;

  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      ST_IDLE, ST_HEADER: s_axis_tready = ~hdr_valid_q;
      ST_PAYLOAD:         s_axis_tready = pay_in_ready;
      ST_DROP:            s_axis_tready = 1'b1;
      default:            s_axis_tready = 1'b0;
    endcase
  end

  // Header bytes only shift while no header is pending, so fields are frozen under m_hdr_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hdr_cnt     <= 4'd0;
      hdr_sr      <= '0;
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (hdr_valid_q && m_hdr_ready) hdr_valid_q <= 1'b0;
      case (state)
        ST_IDLE, ST_HEADER: begin
          if (s_acc) begin
            hdr_sr <= {hdr_sr[HDR_W-DATA_WIDTH-1:0], s_axis_tdata};
            if (s_axis_tlast) begin
              state   <= ST_IDLE;
              hdr_cnt <= 4'd0;
              if (is_last_hdr_byte(hdr_cnt)) hdr_valid_q <= 1'b1;
              else                           err_q       <= 1'b1;
            end else if (s_axis_tuser) begin
              state   <= ST_DROP;
              hdr_cnt <= 4'd0;
            end else if (is_last_hdr_byte(hdr_cnt)) begin
              state       <= ST_PAYLOAD;
              hdr_cnt     <= 4'd0;
              hdr_valid_q <= 1'b1;
            end else begin
              state   <= ST_HEADER;
              hdr_cnt <= hdr_cnt + 4'd1;
            end
          end else if (state == ST_IDLE) begin
            hdr_cnt <= 4'd0;
          end
        end
        ST_PAYLOAD: if (s_acc && s_axis_tlast) state <= ST_IDLE;
        ST_DROP:    if (s_acc && s_axis_tlast) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  eth_rx_hdr_parse_axis_reg_1 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_payload_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_tdata  (s_axis_tdata),
    .in_tvalid (pay_in_valid),
    .in_tready (pay_in_ready),
    .in_tlast  (s_axis_tlast),
    .in_tuser  (s_axis_tuser & s_axis_tlast),
    .out_tdata (m_payload_tdata),
    .out_tvalid(m_payload_tvalid),
    .out_tready(m_payload_tready),
    .out_tlast (m_payload_tlast),
    .out_tuser (m_payload_tuser)
  );

  assign m_hdr_valid          = hdr_valid_q;
  assign m_dest_mac           = hdr_sr[HDR_W-1 -: MAC_W];
  assign m_src_mac            = hdr_sr[TYPE_W +: MAC_W];
  assign m_eth_type           = hdr_sr[TYPE_W-1:0];
  assign busy                 = state != ST_IDLE;
  assign error_hdr_early_term = err_q;

endmodule

// File: tb/tb_eth_rx_hdr_parse.sv
// tb/tb_eth_rx_hdr_parse.sv - self-checking bench for eth_rx_hdr_parse
module tb_eth_rx_hdr_parse;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
  logic        m_hdr_valid, m_hdr_ready = 1'b1;
  logic [47:0] m_dest_mac, m_src_mac;
  logic [15:0] m_eth_type;
  logic [7:0]  m_payload_tdata;
  logic        m_payload_tvalid, m_payload_tready = 1'b1, m_payload_tlast, m_payload_tuser;
  logic        busy, error_hdr_early_term;

  always #5 clk = ~clk;

  eth_rx_hdr_parse #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_dest_mac(m_dest_mac), .m_src_mac(m_src_mac), .m_eth_type(m_eth_type),
    .m_payload_tdata(m_payload_tdata), .m_payload_tvalid(m_payload_tvalid),
    .m_payload_tready(m_payload_tready), .m_payload_tlast(m_payload_tlast),
    .m_payload_tuser(m_payload_tuser),
    .busy(busy), .error_hdr_early_term(error_hdr_early_term)
  );

  typedef struct {
    int len;
    int user_pos;
    bit user_last;
    bit rnd;
    int e_hdr;
    int e_pay;
    int e_err;
  } vec_t;

  int            tests = 0;
  int            fails = 0;
  int            hdr_seen, pay_seen, err_seen;
  bit            rand_ready = 1'b0;
  logic [7:0]    fb [0:99];
  logic [111:0]  exp_hdr_q [$];
  logic [9:0]    exp_pay_q [$];
  logic [111:0]  mon_h;
  logic [9:0]    mon_p;
  vec_t          vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic abort_run(input string name);
    tests++;
    fails++;
    $display("FAIL %s bound expired", name);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Frame 0 is the broadcast IPv4 frame; other kinds use a simple per-kind byte pattern.
  task automatic fill_frame(input int kind);
    for (int i = 0; i < 100; i++) fb[i] = 8'(i * 7 + kind * 31 + 3);
    if (kind == 0) begin
      for (int i = 0; i < 6; i++) fb[i] = 8'hFF;
      for (int i = 6; i < 12; i++) fb[i] = 8'((i - 6) * 8'h11);
      fb[12] = 8'h08;
      fb[13] = 8'h00;
      for (int i = 14; i < 100; i++) fb[i] = 8'(i);
    end
  endtask

  task automatic send_frame(input int len, input int user_pos, input bit user_last, input int stop_after);
    int           n;
    bit           drop, has_hdr, acc;
    logic [111:0] h;
    n       = (stop_after >= 0) ? stop_after : len;
    drop    = (user_pos >= 0) && (user_pos < 14) && (user_pos < len - 1);
    has_hdr = (len >= 14) && !drop;
    h = '0;
    for (int i = 0; i < 14; i++) h = {h[103:0], fb[i]};
    if (has_hdr) exp_hdr_q.push_back(h);
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = fb[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = (i == user_pos) || (user_last && i == len - 1);
      acc = 1'b0;
      for (int g = 0; g < 500 && !acc; g++) begin
        @(negedge clk);
        acc = s_axis_tready;
        if (!acc) begin
          @(posedge clk);
          #1;
        end
      end
      if (!acc) abort_run("s_axis_tready_wait");
      if (has_hdr && i >= 14) exp_pay_q.push_back({user_last && (i == len - 1), i == len - 1, fb[i]});
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int g = 0; g < 2000 && !done; g++) begin
      @(negedge clk);
      done = (exp_pay_q.size() == 0) && (exp_hdr_q.size() == 0) && !m_payload_tvalid;
    end
    if (!done) abort_run("drain_wait");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_hdr_valid && m_hdr_ready) begin
        hdr_seen++;
        if (exp_hdr_q.size() == 0) check("hdr_unexpected", 64'd1, 64'd0);
        else begin
          mon_h = exp_hdr_q.pop_front();
          check("dest_mac", 64'(m_dest_mac), 64'(mon_h[111:64]));
          check("src_mac", 64'(m_src_mac), 64'(mon_h[63:16]));
          check("eth_type", 64'(m_eth_type), 64'(mon_h[15:0]));
        end
      end
      if (m_payload_tvalid && m_payload_tready) begin
        pay_seen++;
        if (exp_pay_q.size() == 0) check("payload_unexpected", 64'd1, 64'd0);
        else begin
          mon_p = exp_pay_q.pop_front();
          check("payload_beat", 64'({m_payload_tuser, m_payload_tlast, m_payload_tdata}), 64'(mon_p));
        end
      end
      if (error_hdr_early_term) err_seen++;
    end
  end

  always @(posedge clk) begin
    #1;
    m_payload_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    vecs[0] = '{60, -1, 1'b0, 1'b0, 1, 46, 0};
    vecs[1] = '{14, -1, 1'b0, 1'b0, 1, 0, 0};
    vecs[2] = '{10, -1, 1'b0, 1'b0, 0, 0, 1};
    vecs[3] = '{13, -1, 1'b0, 1'b0, 0, 0, 1};
    vecs[4] = '{1,  -1, 1'b0, 1'b0, 0, 0, 1};
    vecs[5] = '{30, -1, 1'b1, 1'b1, 1, 16, 0};
    vecs[6] = '{20,  5, 1'b0, 1'b0, 0, 0, 0};
    vecs[7] = '{40, 20, 1'b1, 1'b1, 1, 26, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hdr_valid", 64'(m_hdr_valid), 64'd0);
    check("rst_payload_tvalid", 64'(m_payload_tvalid), 64'd0);
    check("rst_payload_tlast", 64'(m_payload_tlast), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(error_hdr_early_term), 64'd0);
    check("rst_dest_mac", 64'(m_dest_mac), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_tready", 64'(s_axis_tready), 64'd1);
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      fill_frame(v);
      rand_ready = vecs[v].rnd;
      hdr_seen = 0; pay_seen = 0; err_seen = 0;
      send_frame(vecs[v].len, vecs[v].user_pos, vecs[v].user_last, -1);
      wait_drain();
      rand_ready = 1'b0;
      check($sformatf("v%0d_hdr_count", v), 64'(hdr_seen), 64'(vecs[v].e_hdr));
      check($sformatf("v%0d_payload_count", v), 64'(pay_seen), 64'(vecs[v].e_pay));
      check($sformatf("v%0d_err_count", v), 64'(err_seen), 64'(vecs[v].e_err));
      check($sformatf("v%0d_busy_after", v), 64'(busy), 64'd0);
    end

    // Header backpressure: frame 1 header held, next frame must stall in IDLE.
    fill_frame(0);
    hdr_seen = 0; pay_seen = 0; err_seen = 0;
    m_hdr_ready = 1'b0;
    send_frame(60, -1, 1'b0, -1);
    fill_frame(5);
    fork
      send_frame(20, -1, 1'b0, -1);
      begin
        repeat (20) begin
          @(negedge clk);
          check("bp_hdr_valid", 64'(m_hdr_valid), 64'd1);
          check("bp_s_tready", 64'(s_axis_tready), 64'd0);
          check("bp_dest_stable", 64'(m_dest_mac), 64'hFFFF_FFFF_FFFF);
          check("bp_src_stable", 64'(m_src_mac), 64'h0011_2233_4455);
          check("bp_type_stable", 64'(m_eth_type), 64'h0800);
        end
        @(posedge clk);
        #1;
        m_hdr_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_hdr_count", 64'(hdr_seen), 64'd2);
    check("bp_payload_count", 64'(pay_seen), 64'd52);

    // Reset asserted in the middle of the payload, then a clean frame.
    fill_frame(0);
    send_frame(60, -1, 1'b0, 34);
    s_axis_tdata  = fb[34];
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_payload_tvalid", 64'(m_payload_tvalid), 64'd0);
    check("mid_rst_hdr_valid", 64'(m_hdr_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_dest_mac", 64'(m_dest_mac), 64'd0);
    check("mid_rst_payload_tdata", 64'(m_payload_tdata), 64'd0);
    s_axis_tvalid = 1'b0;
    exp_hdr_q.delete();
    exp_pay_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill_frame(3);
    hdr_seen = 0; pay_seen = 0; err_seen = 0;
    send_frame(25, -1, 1'b0, -1);
    wait_drain();
    check("post_rst_hdr_count", 64'(hdr_seen), 64'd1);
    check("post_rst_payload_count", 64'(pay_seen), 64'd11);
    check("post_rst_err_count", 64'(err_seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
